// File: rtl/remote_comm.sv
`default_nettype none
// ============================================================================
//  Module      : remote_comm
//  Description : Serializes a 16-bit command word as two back-to-back UART
//                frames (high byte first, 8N1, LSB first) on TX. Reports
//                progress on busy and completion on a sticky cmd_sent flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module remote_comm #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        TX,
  output logic        busy,
  output logic        cmd_sent
);

  localparam int             BAUD_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [3:0]     BIT_LAST  = 4'd10;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_TX_HIGH = 2'd1;
  localparam logic [1:0] S_TX_LOW  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [15:0]       hold_q,  hold_d;
  logic [9:0]        shift_q, shift_d;
  logic [BAUD_W-1:0] baud_q,  baud_d;
  logic [3:0]        bit_q,   bit_d;
  logic              tx_q,    tx_d;
  logic              sent_q,  sent_d;
  logic              bit_boundary;

  // A new bit is emitted one clock after accept (bit_q==0) and then every
  // BAUD_DIV clocks once the baud counter reaches its last count.
  assign bit_boundary = (bit_q == 4'd0) || (baud_q == BAUD_LAST);

  // Next-state logic for the command FSM, frame shifter and counters.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    shift_d = shift_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    sent_d  = sent_q;
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        bit_d  = 4'd0;
        if (snd_cmd) begin
          hold_d  = cmd;
          shift_d = {1'b1, cmd[15:8], 1'b0};
          sent_d  = 1'b0;
          state_d = S_TX_HIGH;
        end
      end
      S_TX_HIGH, S_TX_LOW: begin
        if (bit_boundary) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            if (state_q == S_TX_HIGH) begin
              // Low byte start bit goes out on the same edge that ends the
              // high byte stop bit, so the two frames are contiguous.
              state_d = S_TX_LOW;
              tx_d    = 1'b0;
              shift_d = {1'b1, 1'b1, hold_q[7:0]};
              bit_d   = 4'd1;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
              bit_d   = 4'd0;
              sent_d  = 1'b1;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b1, shift_q[9:1]};
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        baud_d  = '0;
        bit_d   = 4'd0;
      end
    endcase
  end

  // State registers with asynchronous reset to the idle line condition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      shift_q <= '0;
      baud_q  <= '0;
      bit_q   <= 4'd0;
      tx_q    <= 1'b1;
      sent_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      sent_q  <= sent_d;
    end
  end

  assign TX       = tx_q;
  assign busy     = (state_q != S_IDLE);
  assign cmd_sent = sent_q;

endmodule
`default_nettype wire
